// File: rtl/bcd_scan_counter_pkg.sv
`default_nettype none
// Shared constants for the BCD scan counter: active-low {dp,g..a} glyphs and digit helpers.
package bcd_scan_counter_pkg;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [7:0] BLANK_SEG = 8'hFF;

  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return BLANK_SEG;
    endcase
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// One BCD digit of the counter chain: steps up or down when cin is set, cout flags wrap.
module bcd_digit_cell
  import bcd_scan_counter_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] digit_next,
  output logic       cout
);

  always_comb begin
    digit_next = digit;
    cout       = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit >= DIGIT_MAX) begin
          digit_next = 4'd0;
          cout       = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          digit_next = DIGIT_MAX;
          cout       = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_counter.sv
`default_nettype none
// Prescaled up/down BCD counter with a multiplexed, leading-zero-blanked seven-segment driver.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  wrap,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  logic [PW-1:0]         pre_q, pre_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;

  logic                  tick;
  logic [N_DIGITS:0]     carry;
  logic [4*N_DIGITS-1:0] stepped;
  logic [4*N_DIGITS-1:0] loaded;
  logic [N_DIGITS-1:0]   lz;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  cur_blank;

  assign tick     = en && (pre_q == PRE_LAST);
  assign carry[0] = tick;

  // Ripple chain: the carry out of the top cell is the wrap condition.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit      (count_q[4*i +: 4]),
      .up         (up),
      .cin        (carry[i]),
      .digit_next (stepped[4*i +: 4]),
      .cout       (carry[i+1])
    );
    assign loaded[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
  end

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = loaded;
      pre_d   = '0;
    end else if (en) begin
      if (tick) begin
        pre_d   = '0;
        count_d = stepped;
        wrap_d  = carry[N_DIGITS];
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (count_q[4*i +: 4] == 4'd0);
      lz[i]    = zero_run && (BLANK_LZ != 0);
    end
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = count_q[4*i +: 4];
        cur_blank = lz[i];
        an_d[i]   = 1'b0;
      end
    end
    sseg_d = cur_blank ? BLANK_SEG : glyph(cur_digit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      an_q    <= '1;
      sseg_q  <= BLANK_SEG;
    end else begin
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign sseg  = sseg_q;

endmodule
`default_nettype wire
